// File: rtl/prbs7_pkg.sv
// Shared PRBS7 (x^7 + x^6 + 1) definitions: default seed, injection mode
// encodings and the unrolled 64-bit word function reused by checker models.
package prbs7_pkg;

  localparam int unsigned PRBS7_WORD_W       = 64;
  localparam logic [6:0]  PRBS7_SEED_DEFAULT = 7'h7F;

  typedef enum logic [1:0] {
    INJ_OFF      = 2'd0,
    INJ_SINGLE   = 2'd1,
    INJ_PERIODIC = 2'd2,
    INJ_RESERVED = 2'd3
  } inject_mode_e;

  // x[6:0] holds x(-7..-1) with the oldest bit in x[0]; x[k+7] is word bit k.
  function automatic logic [PRBS7_WORD_W-1:0] prbs7_word(input logic [6:0] state);
    logic [PRBS7_WORD_W+6:0] x;
    x      = '0;
    x[6:0] = state;
    for (int k = 0; k < PRBS7_WORD_W; k++) begin
      x[k+7] = x[k] ^ x[k+1];
    end
    return x[PRBS7_WORD_W+6:7];
  endfunction

endpackage

// File: rtl/prbs7_inject_ctrl.sv
// Error-injection control: trigger edge detect, single-shot arm flag,
// periodic word counter and the saturating injected-word counter.
module prbs7_inject_ctrl
  import prbs7_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_emit,
  input  logic [1:0]              i_injectMode,
  input  logic                    i_injectTrig,
  input  logic [15:0]             i_injectPeriod,
  input  logic [5:0]              i_injectBit,
  input  logic                    i_clearCount,
  output logic [PRBS7_WORD_W-1:0] o_flipMask,
  output logic                    o_injected,
  output logic [15:0]             o_injectCount
);

  inject_mode_e w_mode;
  inject_mode_e r_modePrev;
  logic         r_trigD;
  logic         r_armed;
  logic [15:0]  r_periodCnt;
  logic [15:0]  r_injectCount;
  logic         w_modeChange;
  logic         w_trigRise;
  logic         w_armed;
  logic [15:0]  w_periodCnt;
  logic         w_inject;

  assign w_mode       = inject_mode_e'(i_injectMode);
  assign w_modeChange = (w_mode != r_modePrev);
  assign w_trigRise   = i_injectTrig & ~r_trigD;

  // A mode change wipes the arm flag and counter before they are used this cycle.
  assign w_armed     = r_armed & ~w_modeChange;
  assign w_periodCnt = w_modeChange ? 16'd0 : r_periodCnt;

  always_comb begin
    w_inject = 1'b0;
    if (i_emit) begin
      case (w_mode)
        INJ_SINGLE:   w_inject = w_armed;
        INJ_PERIODIC: w_inject = (w_periodCnt == i_injectPeriod);
        default:      w_inject = 1'b0;
      endcase
    end
  end

  assign o_flipMask    = w_inject ? ({{(PRBS7_WORD_W-1){1'b0}}, 1'b1} << i_injectBit) : '0;
  assign o_injected    = w_inject;
  assign o_injectCount = r_injectCount;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_modePrev    <= INJ_OFF;
      r_trigD       <= 1'b0;
      r_armed       <= 1'b0;
      r_periodCnt   <= 16'd0;
      r_injectCount <= 16'd0;
    end else begin
      r_modePrev <= w_mode;
      r_trigD    <= i_injectTrig;

      if (w_mode != INJ_SINGLE) begin
        r_armed <= 1'b0;
      end else if (w_inject) begin
        r_armed <= 1'b0;
      end else if (w_trigRise) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= w_armed;
      end

      if (w_mode != INJ_PERIODIC) begin
        r_periodCnt <= 16'd0;
      end else if (!i_emit) begin
        r_periodCnt <= w_periodCnt;
      end else if (w_inject) begin
        r_periodCnt <= 16'd0;
      end else begin
        r_periodCnt <= w_periodCnt + 16'd1;
      end

      if (i_clearCount) begin
        r_injectCount <= 16'd0;
      end else if (w_inject && (r_injectCount != 16'hFFFF)) begin
        r_injectCount <= r_injectCount + 16'd1;
      end
    end
  end

endmodule

// File: rtl/prbs7_gen_inject.sv
// PRBS7 word transmitter: one 64-bit word per clock from an unrolled LFSR,
// with optional bit flips applied after the state update.
module prbs7_gen_inject
  import prbs7_pkg::*;
#(
  parameter int         WORDWIDTH = PRBS7_WORD_W,
  parameter logic [6:0] SEEDRST   = PRBS7_SEED_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_dis,
  input  logic                 i_loadSeed,
  input  logic [6:0]           i_seed,
  input  logic [1:0]           i_injectMode,
  input  logic                 i_injectTrig,
  input  logic [15:0]          i_injectPeriod,
  input  logic [5:0]           i_injectBit,
  input  logic                 i_clearCount,
  output logic [WORDWIDTH-1:0] o_dout,
  output logic                 o_dataValid,
  output logic                 o_injected,
  output logic [15:0]          o_injectCount
);

  logic [6:0]           r_state;
  logic [WORDWIDTH-1:0] r_dout;
  logic                 r_dataValid;
  logic                 r_injected;
  logic [WORDWIDTH-1:0] w_word;
  logic [WORDWIDTH-1:0] w_flipMask;
  logic                 w_injected;
  logic                 w_emit;
  logic [6:0]           w_seedSafe;

  assign w_word     = prbs7_word(r_state);
  assign w_emit     = ~i_loadSeed & ~i_dis;
  assign w_seedSafe = (i_seed == 7'd0) ? PRBS7_SEED_DEFAULT : i_seed;

  prbs7_inject_ctrl u_ctrl (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_emit         (w_emit),
    .i_injectMode   (i_injectMode),
    .i_injectTrig   (i_injectTrig),
    .i_injectPeriod (i_injectPeriod),
    .i_injectBit    (i_injectBit),
    .i_clearCount   (i_clearCount),
    .o_flipMask     (w_flipMask),
    .o_injected     (w_injected),
    .o_injectCount  (o_injectCount)
  );

  // The LFSR advances on the clean word so a flipped bit never propagates.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= SEEDRST;
      r_dout      <= '0;
      r_dataValid <= 1'b0;
      r_injected  <= 1'b0;
    end else if (i_loadSeed) begin
      r_state     <= w_seedSafe;
      r_dataValid <= 1'b0;
    end else if (i_dis) begin
      r_dataValid <= 1'b0;
    end else begin
      r_state     <= w_word[WORDWIDTH-1:WORDWIDTH-7];
      r_dout      <= w_word ^ w_flipMask;
      r_dataValid <= 1'b1;
      r_injected  <= w_injected;
    end
  end

  assign o_dout      = r_dout;
  assign o_dataValid = r_dataValid;
  assign o_injected  = r_injected;

endmodule

// File: tb/tb_prbs7_gen_inject.sv
// Self-checking bench for prbs7_gen_inject: randomized stimulus scored against
// a bit-stream model of x(n) = x(n-7) ^ x(n-6) and of the injection rules.
module tb_prbs7_gen_inject;

  logic        clk = 1'b0;
  logic        reset;
  logic        dis;
  logic        loadSeed;
  logic [6:0]  seed;
  logic [1:0]  injectMode;
  logic        injectTrig;
  logic [15:0] injectPeriod;
  logic [5:0]  injectBit;
  logic        clearCount;
  logic [63:0] dout;
  logic        dataValid;
  logic        injected;
  logic [15:0] injectCount;

  int          checkCount = 0;
  int          passCount  = 0;
  bit          mHist[$];
  logic [63:0] expDout;

  always #5 clk = ~clk;

  prbs7_gen_inject dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_dis          (dis),
    .i_loadSeed     (loadSeed),
    .i_seed         (seed),
    .i_injectMode   (injectMode),
    .i_injectTrig   (injectTrig),
    .i_injectPeriod (injectPeriod),
    .i_injectBit    (injectBit),
    .i_clearCount   (clearCount),
    .o_dout         (dout),
    .o_dataValid    (dataValid),
    .o_injected     (injected),
    .o_injectCount  (injectCount)
  );

  // Model keeps the last seven stream bits, oldest at the front.
  function automatic void modelSeed(input logic [6:0] s);
    logic [6:0] eff;
    eff = (s == 7'h00) ? 7'h7F : s;
    mHist.delete();
    for (int i = 0; i < 7; i++) mHist.push_back(eff[i]);
  endfunction

  function automatic logic [63:0] modelWord();
    logic [63:0] w;
    for (int k = 0; k < 64; k++) begin
      w[k] = mHist[mHist.size()-7] ^ mHist[mHist.size()-6];
      mHist.push_back(w[k]);
      void'(mHist.pop_front());
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] exp;
    reset = 1'b0;
    tick();
    tick();
    checkCount++; if (dout !== 64'd0) $display("[TB] FAIL reset_dout got=%h want=%h", dout, 64'd0); else passCount++;
    checkCount++; if (dataValid !== 1'b0) $display("[TB] FAIL reset_valid got=%b want=0", dataValid); else passCount++;
    checkCount++; if (injected !== 1'b0) $display("[TB] FAIL reset_injected got=%b want=0", injected); else passCount++;
    checkCount++; if (injectCount !== 16'd0) $display("[TB] FAIL reset_count got=%h want=0", injectCount); else passCount++;
    reset = 1'b1;
    modelSeed(7'h7F);
    tick();
    exp = modelWord();
    expDout = exp;
    checkCount++; if (dataValid !== 1'b1) $display("[TB] FAIL first_valid got=%b want=1", dataValid); else passCount++;
    checkCount++; if (dout[6:0] !== 7'h40) $display("[TB] FAIL first_low_bits got=%h want=40", dout[6:0]); else passCount++;
    checkCount++; if (dout !== exp) $display("[TB] FAIL first_word got=%h want=%h", dout, exp); else passCount++;
  endtask

  // Words 1..253 are predicted from one 127-bit period of the sequence.
  task automatic test_stream();
    bit          per[127];
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] exp;
    modelSeed(7'h7F);
    w0 = modelWord();
    w1 = modelWord();
    for (int k = 0; k < 127; k++) per[k] = (k < 64) ? w0[k] : w1[k-64];
    for (int n = 1; n < 254; n++) begin
      tick();
      for (int i = 0; i < 64; i++) exp[i] = per[(64*n + i) % 127];
      expDout = exp;
      checkCount++; if (dataValid !== 1'b1 || dout !== exp) $display("[TB] FAIL stream_word%0d got=%h/%b want=%h/1", n, dout, dataValid, exp); else passCount++;
    end
  endtask

  task automatic test_load_seed();
    logic [63:0] exp;
    loadSeed = 1'b1;
    seed     = 7'h00;
    tick();
    checkCount++; if (dataValid !== 1'b0) $display("[TB] FAIL load0_valid got=%b want=0", dataValid); else passCount++;
    checkCount++; if (dout !== expDout) $display("[TB] FAIL load0_hold got=%h want=%h", dout, expDout); else passCount++;
    loadSeed = 1'b0;
    modelSeed(7'h7F);
    for (int n = 0; n < 8; n++) begin
      tick();
      exp = modelWord();
      expDout = exp;
      checkCount++; if (dataValid !== 1'b1 || dout !== exp) $display("[TB] FAIL seed00_word%0d got=%h want=%h", n, dout, exp); else passCount++;
    end
    loadSeed = 1'b1;
    seed     = 7'h01;
    tick();
    checkCount++; if (dataValid !== 1'b0) $display("[TB] FAIL load1_valid got=%b want=0", dataValid); else passCount++;
    loadSeed = 1'b0;
    modelSeed(7'h01);
    for (int n = 0; n < 8; n++) begin
      tick();
      exp = modelWord();
      expDout = exp;
      checkCount++; if (dataValid !== 1'b1 || dout !== exp) $display("[TB] FAIL seed01_word%0d got=%h want=%h", n, dout, exp); else passCount++;
    end
  endtask

  // Random seed loads, freezes and trigger noise with injection off.
  task automatic test_random_ctrl();
    int r;
    for (int n = 0; n < 300; n++) begin
      r          = $urandom_range(0, 9);
      loadSeed   = (r == 0);
      dis        = (r == 1 || r == 2);
      seed       = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom());
      injectTrig = 1'($urandom());
      tick();
      if (loadSeed) begin
        modelSeed(seed);
        checkCount++; if (dataValid !== 1'b0 || dout !== expDout) $display("[TB] FAIL rnd_load%0d got=%h/%b want=%h/0", n, dout, dataValid, expDout); else passCount++;
      end else if (dis) begin
        checkCount++; if (dataValid !== 1'b0 || dout !== expDout) $display("[TB] FAIL rnd_dis%0d got=%h/%b want=%h/0", n, dout, dataValid, expDout); else passCount++;
      end else begin
        expDout = modelWord();
        checkCount++; if (dataValid !== 1'b1 || dout !== expDout || injected !== 1'b0) $display("[TB] FAIL rnd_word%0d got=%h/%b/%b want=%h/1/0", n, dout, dataValid, injected, expDout); else passCount++;
      end
    end
    loadSeed   = 1'b0;
    dis        = 1'b0;
    injectTrig = 1'b0;
    tick();
    expDout = modelWord();
    checkCount++; if (injectCount !== 16'd0) $display("[TB] FAIL rnd_count got=%h want=0", injectCount); else passCount++;
  endtask

  task automatic test_single_shot();
    bit          armedM;
    bit          prevTrig;
    bit          edgeM;
    bit          inj;
    int          expCount;
    logic [63:0] exp;
    injectMode = 2'd1;
    injectBit  = 6'd37;
    armedM     = 1'b0;
    prevTrig   = 1'b0;
    expCount   = 0;
    for (int n = 0; n < 70; n++) begin
      dis = (n >= 10) && ($urandom_range(0, 3) == 0);
      if (n < 10) injectTrig = (n == 2);
      else if (!dis) injectTrig = 1'($urandom());
      if (n >= 10) injectBit = 6'($urandom_range(0, 63));
      tick();
      edgeM    = injectTrig && !prevTrig;
      prevTrig = injectTrig;
      if (dis) begin
        armedM = armedM | edgeM;
        checkCount++; if (dataValid !== 1'b0 || dout !== expDout) $display("[TB] FAIL single_dis%0d got=%h want=%h", n, dout, expDout); else passCount++;
      end else begin
        exp    = modelWord();
        inj    = armedM;
        armedM = inj ? 1'b0 : (armedM | edgeM);
        if (inj) expCount++;
        expDout = inj ? (exp ^ (64'd1 << injectBit)) : exp;
        checkCount++; if (dout !== expDout || injected !== inj) $display("[TB] FAIL single_word%0d got=%h/%b want=%h/%b", n, dout, injected, expDout, inj); else passCount++;
      end
      if (n == 9) begin
        checkCount++; if (injectCount !== 16'd1) $display("[TB] FAIL single_count got=%h want=1", injectCount); else passCount++;
      end
    end
    checkCount++; if (injectCount !== 16'(expCount)) $display("[TB] FAIL single_rnd_count got=%h want=%h", injectCount, 16'(expCount)); else passCount++;
    dis        = 1'b0;
    injectTrig = 1'b0;
  endtask

  task automatic test_periodic();
    int          emitted;
    int          disLeft;
    bit          didDis;
    bit          inj;
    logic [63:0] exp;
    dis          = 1'b1;
    clearCount   = 1'b1;
    injectMode   = 2'd2;
    injectPeriod = 16'd9;
    injectBit    = 6'($urandom_range(0, 63));
    tick();
    checkCount++; if (injectCount !== 16'd0 || dataValid !== 1'b0) $display("[TB] FAIL per_clear got=%h/%b want=0/0", injectCount, dataValid); else passCount++;
    clearCount = 1'b0;
    emitted    = 0;
    disLeft    = 0;
    didDis     = 1'b0;
    while (emitted < 100) begin
      if (!didDis && emitted == 45) begin
        disLeft = 5;
        didDis  = 1'b1;
      end
      dis = (disLeft > 0);
      if (disLeft > 0) disLeft--;
      tick();
      if (dis) begin
        checkCount++; if (dataValid !== 1'b0 || dout !== expDout) $display("[TB] FAIL per_dis got=%h want=%h", dout, expDout); else passCount++;
      end else begin
        emitted++;
        inj     = (emitted % 10 == 0);
        exp     = modelWord();
        expDout = inj ? (exp ^ (64'd1 << injectBit)) : exp;
        checkCount++; if (dout !== expDout || injected !== inj) $display("[TB] FAIL per_word%0d got=%h/%b want=%h/%b", emitted, dout, injected, expDout, inj); else passCount++;
      end
    end
    checkCount++; if (injectCount !== 16'd10) $display("[TB] FAIL per_count got=%h want=000a", injectCount); else passCount++;
  endtask

  task automatic test_saturation();
    dis        = 1'b0;
    injectMode = 2'd0;
    clearCount = 1'b1;
    tick();
    checkCount++; if (injectCount !== 16'd0) $display("[TB] FAIL sat_clear got=%h want=0", injectCount); else passCount++;
    clearCount   = 1'b0;
    injectMode   = 2'd2;
    injectPeriod = 16'd0;
    repeat (65534) tick();
    checkCount++; if (injectCount !== 16'hFFFE) $display("[TB] FAIL sat_fffe got=%h want=fffe", injectCount); else passCount++;
    tick();
    checkCount++; if (injectCount !== 16'hFFFF) $display("[TB] FAIL sat_ffff got=%h want=ffff", injectCount); else passCount++;
    tick();
    tick();
    checkCount++; if (injectCount !== 16'hFFFF || injected !== 1'b1) $display("[TB] FAIL sat_hold got=%h/%b want=ffff/1", injectCount, injected); else passCount++;
    clearCount = 1'b1;
    tick();
    checkCount++; if (injectCount !== 16'd0 || injected !== 1'b1) $display("[TB] FAIL sat_clear_inject got=%h/%b want=0000/1", injectCount, injected); else passCount++;
    clearCount = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [63:0] exp;
    injectPeriod = 16'd3;
    repeat (6) tick();
    #3;
    reset = 1'b0;
    #1;
    checkCount++; if (dout !== 64'd0 || injectCount !== 16'd0) $display("[TB] FAIL midrst_now got=%h/%h want=0/0", dout, injectCount); else passCount++;
    checkCount++; if (dataValid !== 1'b0 || injected !== 1'b0) $display("[TB] FAIL midrst_flags got=%b/%b want=0/0", dataValid, injected); else passCount++;
    injectMode = 2'd0;
    tick();
    tick();
    checkCount++; if (dataValid !== 1'b0 || dout !== 64'd0) $display("[TB] FAIL midrst_held got=%h/%b want=0/0", dout, dataValid); else passCount++;
    reset = 1'b1;
    modelSeed(7'h7F);
    for (int n = 0; n < 30; n++) begin
      tick();
      exp = modelWord();
      checkCount++; if (dataValid !== 1'b1 || dout !== exp) $display("[TB] FAIL midrst_word%0d got=%h want=%h", n, dout, exp); else passCount++;
    end
  endtask

  initial begin
    reset        = 1'b0;
    dis          = 1'b0;
    loadSeed     = 1'b0;
    seed         = 7'h00;
    injectMode   = 2'd0;
    injectTrig   = 1'b0;
    injectPeriod = 16'd0;
    injectBit    = 6'd0;
    clearCount   = 1'b0;
    expDout      = 64'd0;
    test_reset();
    test_stream();
    test_load_seed();
    test_random_ctrl();
    test_single_shot();
    test_periodic();
    test_saturation();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/prbs7_gen_inject.md
Name: prbs7_gen_inject

Overview:
- PRBS7 pattern transmitter for the ETROC2 readout link test.
- Produces one 64-bit word per clock, with optional deterministic bit-error injection.
- Drives the serializer side of the SERDES loop; the PRBS7 checker at the far end counts injected errors.
- Injected errors never enter the LFSR state, so each injected bit produces exactly one checker error bit.

Parameters:
- WORDWIDTH, 64, bits emitted per clock; fixed at 64 for this link.
- SEEDRST, 7'h7F, LFSR state loaded at reset.

Ports:
- clk  input  1  word clock
- reset  input  1  asynchronous, active-low reset
- dis  input  1  1 = freeze generator: state and dout hold, dataValid=0
- loadSeed  input  1  1-cycle pulse: load seed into LFSR state
- seed  input  7  seed value; 7'h00 is replaced by 7'h7F
- injectMode  input  2  0 off, 1 single-shot, 2 periodic, 3 reserved (treated as off)
- injectTrig  input  1  rising edge arms one single-shot injection
- injectPeriod  input  16  periodic mode: inject every injectPeriod+1 words
- injectBit  input  6  bit position flipped in dout
- clearCount  input  1  synchronous clear of injectCount
- dout  output  64  PRBS word; dout[0] is serialized first
- dataValid  output  1  dout updated this cycle
- injected  output  1  current dout contains an injected error
- injectCount  output  16  saturating count of injected words

Behaviour:
- Reset values (async, reset=0):
  - state=SEEDRST
  - dout=0, dataValid=0, injected=0, injectCount=0
  - period counter=0, armed=0, trig delay reg=0
- Sequence: x(n) = x(n-7) XOR x(n-6), i.e. x^7+x^6+1.
- State s[6:0] holds the last 7 emitted bits; s[0] is oldest.
- Word generation: dout[i] = x(i-7) ^ x(i-6), where x(-7..-1) = s[0..6] and x(k) = dout[k] for k≥0. Fully unrolled combinational chain; output registered.
- Next state = un-injected dout[63:57].
- Latency: 1 cycle from enable/seed to the first registered word.
- Per-cycle priority:
  1. loadSeed: state <= seed (0→7'h7F); dout holds; dataValid=0.
  2. dis: everything holds; dataValid=0.
  3. Otherwise: emit word, dataValid=1.
- Single-shot (mode 1):
  - Rising edge of injectTrig sets armed.
  - The next emitted word is XORed with (1<<injectBit); that clears armed.
  - An edge while already armed is ignored, i.e. at most one pending injection.
- Periodic (mode 2):
  - 16-bit counter increments on each emitted word.
  - When counter == injectPeriod, inject and wrap the counter to 0.
  - injectPeriod=0 injects every word.
  - The counter holds while dis or loadSeed is active.
- Mode change: counter resets to 0 and armed clears on any injectMode change.
- injected: registered alongside dout; 1 only on words carrying a flip.
- injectCount:
  - +1 per injected word; saturates at 16'hFFFF.
  - clearCount has priority over increment in the same cycle (result 0).
- Reset mid-stream: outputs return to reset values immediately. After release the stream restarts from SEEDRST, so the sequence is identical to power-up.

Decomposition:
- Shared package prbs7_pkg:
  - PRBS7_SEED_DEFAULT (7'h7F)
  - injectMode encodings INJ_OFF / INJ_SINGLE / INJ_PERIODIC
  - function prbs7_word(state) returning the 64-bit unrolled word; reused by checker-side models.
- One sub-module, prbs7_inject_ctrl: trigger edge detect, armed flag, period counter, injectCount. It outputs flip mask and injected.

Test Plan:
- Reset release, dis=0, mode 0:
  - dataValid=1 from the 1st clock.
  - First word has dout[5:0]=0 and dout[6]=1.
  - Consecutive words match the prbs7_pkg model for 254 words; period 127 bits repeats exactly.
- loadSeed with seed=7'h00, then seed=7'h01:
  - 7'h00 gives the same stream as 7'h7F.
  - 7'h01 stream matches the model.
  - dataValid=0 on load cycles.
- Mode 1, injectBit=37, one injectTrig pulse:
  - Exactly one word differs from the model, only at bit 37; injected=1 on that word.
  - injectCount=1.
  - The following word is un-corrupted.
- Mode 2, injectPeriod=9, run 100 words:
  - Injections on words 10, 20, …, 100; injectCount=10.
  - Toggling dis for 5 cycles mid-run shifts no injection position relative to emitted words.
- injectCount saturation:
  - Force to 16'hFFFE, inject 3 words → 16'hFFFF.
  - clearCount plus an injection in the same cycle → 0.
- Async reset asserted mid-word in mode 2:
  - dout=0 and injectCount=0 immediately.
  - After release, the stream equals the power-up stream.
